// File: rtl/pci_burst_initiator.sv
// Bus-master burst engine for PCI-style sram_64-class targets: fetches host write data,
// issues one address phase per beat, checks for a target claim and ends on count, stop or abort.
module pci_burst_initiator #(
  parameter int unsigned DEVSEL_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic        cmd_req64,
  input  logic [7:0]  cmd_be,
  input  logic [63:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [63:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [8:0]  beats_done,
  output logic [31:0] add_out,
  output logic [63:0] wr_data,
  output logic [7:0]  be_out,
  output logic        we_out,
  output logic        req_64,
  input  logic        devsel_32,
  input  logic        devsel_64,
  input  logic        last_add,
  input  logic [63:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ADDR, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] TO_LIMIT = 4'(DEVSEL_TIMEOUT);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic        r_req64;
  logic [7:0]  r_be;
  logic [8:0]  r_len;
  logic [29:0] r_word;
  logic [3:0]  r_to;

  logic        w_claim;
  logic        w_wide;
  logic [8:0]  w_beats_inc;
  logic        w_last;
  logic [3:0]  w_to_inc;
  logic        w_to_hit;
  logic        w_we_sel;
  logic        w_req64_sel;
  logic [7:0]  w_be_sel;
  logic [29:0] w_word_sel;
  logic        w_unused_addr;

  assign w_unused_addr = ^cmd_addr[1:0];

  assign w_claim     = !devsel_32 || !devsel_64;
  assign w_wide      = !devsel_64 && req_64;
  assign w_beats_inc = beats_done + 9'd1;
  assign w_last      = (w_beats_inc == r_len);
  assign w_to_inc    = r_to + 4'd1;
  assign w_to_hit    = (w_to_inc == TO_LIMIT);

  // In IDLE the command is not latched yet, so the first address phase comes straight from cmd_*.
  assign w_we_sel    = (r_state == S_IDLE) ? cmd_we    : r_we;
  assign w_req64_sel = (r_state == S_IDLE) ? cmd_req64 : r_req64;
  assign w_be_sel    = (r_state == S_IDLE) ? cmd_be    : r_be;
  always_comb begin
    w_word_sel = r_word;
    if (r_state == S_IDLE)
      w_word_sel = cmd_addr[31:2];
    else if (r_state == S_CHECK)
      w_word_sel = r_word + 30'd1;
  end

  assign wdata_ready = (r_state == S_FETCH);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cmd_len == 9'd0)
            w_state_next = S_DONE;
          else if (cmd_we)
            w_state_next = S_FETCH;
          else
            w_state_next = S_ADDR;
        end
      end
      S_FETCH: begin
        if (wdata_valid)
          w_state_next = S_ADDR;
      end
      S_ADDR:  w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_claim) begin
          if (w_last || last_add)
            w_state_next = S_DONE;
          else
            w_state_next = r_we ? S_FETCH : S_ADDR;
        end else if (w_to_hit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_req64     <= 1'b0;
      r_be        <= 8'd0;
      r_len       <= 9'd0;
      r_word      <= 30'd0;
      r_to        <= 4'd0;
      rdata       <= 64'd0;
      rdata_valid <= 1'b0;
      status      <= 2'b00;
      beats_done  <= 9'd0;
      add_out     <= 32'd0;
      wr_data     <= 64'd0;
      be_out      <= 8'd0;
      we_out      <= 1'b0;
      req_64      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      rdata_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_we       <= cmd_we;
            r_req64    <= cmd_req64;
            r_be       <= cmd_be;
            r_len      <= cmd_len;
            r_word     <= cmd_addr[31:2];
            r_to       <= 4'd0;
            beats_done <= 9'd0;
            status     <= 2'b00;
          end
        end
        S_FETCH: begin
          if (wdata_valid)
            wr_data <= wdata;
        end
        S_CHECK: begin
          if (w_claim) begin
            beats_done <= w_beats_inc;
            r_word     <= r_word + 30'd1;
            r_to       <= 4'd0;
            if (!r_we) begin
              rdata       <= w_wide ? rd_data : {32'd0, rd_data[31:0]};
              rdata_valid <= 1'b1;
            end
            if (!w_last && last_add)
              status <= 2'b01;
          end else begin
            r_to <= w_to_inc;
            if (w_to_hit)
              status <= 2'b10;
          end
        end
        default: ;
      endcase
      // Bus control is only asserted while an address phase or its check is in progress.
      if (w_state_next == S_ADDR || w_state_next == S_CHECK) begin
        we_out <= w_we_sel;
        req_64 <= w_req64_sel;
      end else begin
        we_out <= 1'b0;
        req_64 <= 1'b0;
      end
      if (w_state_next == S_ADDR) begin
        add_out <= {w_word_sel, 2'b00};
        be_out  <= w_be_sel;
      end
    end
  end

endmodule

// File: tb/tb_pci_burst_initiator.sv
// Directed bench for pci_burst_initiator with a small sram_64-style target model
// covering word indices 0x40..0x4F (bytes 0x100..0x13C).
module tb_pci_burst_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [8:0]  cmd_len = 9'd0;
  logic        cmd_req64 = 1'b0;
  logic [7:0]  cmd_be = 8'd0;
  logic [63:0] wdata = 64'd0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [8:0]  beats_done;
  logic [31:0] add_out;
  logic [63:0] wr_data;
  logic [7:0]  be_out;
  logic        we_out;
  logic        req_64;
  logic        devsel_32 = 1'b1;
  logic        devsel_64 = 1'b1;
  logic        last_add = 1'b0;
  logic [63:0] rd_data = 64'd0;

  pci_burst_initiator #(.DEVSEL_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_req64(cmd_req64), .cmd_be(cmd_be), .wdata(wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .status(status),
    .beats_done(beats_done), .add_out(add_out), .wr_data(wr_data), .be_out(be_out),
    .we_out(we_out), .req_64(req_64), .devsel_32(devsel_32), .devsel_64(devsel_64),
    .last_add(last_add), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Target: registers its claim, data and end flag one edge after seeing the address.
  logic [63:0] mem [0:255];
  bit          mem_init = 1'b0;
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= {8'hD0, 24'(i), 8'hA0, 24'(i)};
      mem_init <= 1'b1;
    end else if (add_out[31:2] >= 30'h40 && add_out[31:2] <= 30'h4F) begin
      devsel_64 <= !req_64;
      devsel_32 <= req_64;
      rd_data   <= mem[add_out[9:2]];
      last_add  <= (add_out[31:2] == 30'h4F);
      if (we_out) begin
        for (int b = 0; b < 8; b++)
          if (be_out[b]) mem[add_out[9:2]][8*b +: 8] <= wr_data[8*b +: 8];
        wr_cnt <= wr_cnt + 1;
      end
    end else begin
      devsel_32 <= 1'b1;
      devsel_64 <= 1'b1;
      rd_data   <= 'z;
      last_add  <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  int          cyc;
  int          done_cyc;
  int          hs_cnt;
  bit          any_bus;
  logic [63:0] rv_data [$];
  int          rv_cyc [$];
  logic [31:0] addr_log [0:63];

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic burst(input logic we, input logic [31:0] addr, input logic [8:0] len,
                       input logic r64, input logic [7:0] be, input bit toggle, input int poke);
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_req64 = r64; cmd_be = be;
    wdata_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; done_cyc = -1; hs_cnt = 0; any_bus = 1'b0;
    rv_data.delete(); rv_cyc.delete();
    while (done_cyc < 0 && cyc < 200) begin
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h2000;
      end else begin
        start = 1'b0;
      end
      wdata_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      wdata = {32'hA000_0000 | 32'(hs_cnt), 32'hB000_0000 | 32'(hs_cnt)};
      @(negedge clk);
      if (wdata_ready && wdata_valid) hs_cnt++;
      if (rdata_valid) begin
        rv_data.push_back(rdata);
        rv_cyc.push_back(cyc);
      end
      if (we_out || req_64) any_bus = 1'b1;
      if (cyc < 64) addr_log[cyc] = add_out;
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addout", 64'(add_out), 64'd0);
    check("rst_we_req", {62'd0, we_out, req_64}, 64'd0);
    check("rst_status_beats", {53'd0, status, beats_done}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-bit read, 4 beats from 0x100
    burst(1'b0, 32'h100, 9'd4, 1'b1, 8'hFF, 1'b0, -1);
    check("rd64_count", 64'(rv_data.size()), 64'd4);
    if (rv_data.size() == 4) begin
      check("rd64_cyc0", 64'(rv_cyc[0]), 64'd3);
      check("rd64_cyc3", 64'(rv_cyc[3]), 64'd9);
      check("rd64_d0", rv_data[0], 64'hD000_0040_A000_0040);
      check("rd64_d1", rv_data[1], 64'hD000_0041_A000_0041);
      check("rd64_d3", rv_data[3], 64'hD000_0043_A000_0043);
    end
    check("rd64_addr1", 64'(addr_log[1]), 64'h100);
    check("rd64_addr3", 64'(addr_log[3]), 64'h104);
    check("rd64_addr7", 64'(addr_log[7]), 64'h10C);
    check("rd64_done_cyc", 64'(done_cyc), 64'd9);
    check("rd64_status", 64'(status), 64'd0);
    check("rd64_beats", 64'(beats_done), 64'd4);

    // 32-bit write, 3 beats, wdata_valid high on even cycles only
    burst(1'b1, 32'h110, 9'd3, 1'b0, 8'h0F, 1'b1, -1);
    check("wr32_hs", 64'(hs_cnt), 64'd3);
    check("wr32_done_cyc", 64'(done_cyc), 64'd13);
    check("wr32_mem44", mem[8'h44], 64'hD000_0044_B000_0000);
    check("wr32_mem45", mem[8'h45], 64'hD000_0045_B000_0001);
    check("wr32_mem46", mem[8'h46], 64'hD000_0046_B000_0002);
    check("wr32_status", 64'(status), 64'd0);
    check("wr32_beats", 64'(beats_done), 64'd3);

    // read outside every target: master abort after 4 CHECK cycles
    burst(1'b0, 32'h1000, 9'd2, 1'b0, 8'hFF, 1'b0, -1);
    check("abort_done_cyc", 64'(done_cyc), 64'd6);
    check("abort_status", 64'(status), 64'd2);
    check("abort_beats", 64'(beats_done), 64'd0);
    check("abort_rv", 64'(rv_data.size()), 64'd0);
    check("abort_addr_held", 64'(addr_log[5]), 64'h1000);

    // 32-bit read of 8 beats starting 2 words below the target end address
    burst(1'b0, 32'h134, 9'd8, 1'b0, 8'hFF, 1'b0, -1);
    check("stop_status", 64'(status), 64'd1);
    check("stop_beats", 64'(beats_done), 64'd3);
    check("stop_rv", 64'(rv_data.size()), 64'd3);
    check("stop_done_cyc", 64'(done_cyc), 64'd7);
    if (rv_data.size() == 3)
      check("stop_d2", rv_data[2], 64'h0000_0000_A000_004F);

    // zero-length command
    burst(1'b1, 32'h100, 9'd0, 1'b1, 8'hFF, 1'b0, -1);
    check("len0_done_cyc", 64'(done_cyc), 64'd1);
    check("len0_bus", 64'(any_bus), 64'd0);
    check("len0_status", 64'(status), 64'd0);

    // start pulsed during CHECK of a busy read burst is ignored
    burst(1'b0, 32'h100, 9'd2, 1'b1, 8'hFF, 1'b0, 2);
    check("busy_start_done_cyc", 64'(done_cyc), 64'd5);
    check("busy_start_beats", 64'(beats_done), 64'd2);
    if (rv_data.size() == 2)
      check("busy_start_d1", rv_data[1], 64'hD000_0041_A000_0041);
    @(negedge clk);
    check("busy_start_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // write burst with reset asserted during CHECK of beat 2 (cycle 6)
    cmd_we = 1'b1; cmd_addr = 32'h120; cmd_len = 9'd3; cmd_req64 = 1'b0; cmd_be = 8'hFF;
    wdata = 64'h1111_2222_3333_4444; wdata_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    begin
      int saved_wr;
      check("rstmid_we_before", 64'(we_out), 64'd1);
      check("rstmid_beats_before", 64'(beats_done), 64'd1);
      saved_wr = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("rstmid_we", 64'(we_out), 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_addout", 64'(add_out), 64'd0);
      check("rstmid_wrdata", wr_data, 64'd0);
      check("rstmid_beats", 64'(beats_done), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wdata_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rstmid_no_writes", 64'(wr_cnt), 64'(saved_wr));
      check("rstmid_mem49", mem[8'h49], 64'h1111_2222_3333_4444);
      check("rstmid_mem4a", mem[8'h4A], 64'hD000_004A_A000_004A);
      check("rstmid_idle", 64'(busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
